// File: rtl/spm_drv_pkg.sv
// Shared types and sizing helpers for the spm operand driver.
package spm_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_SIZE = 32;
    localparam int CNT_W    = $clog2(2*DEF_SIZE+1);

    // Counter width able to hold 0..2*size.
    function automatic int cnt_width(input int size);
        return $clog2(2*size+1);
    endfunction

endpackage

// File: rtl/spm_prod_sipo.sv
// Serial-in/parallel-out product register. Bits enter at the MSB and move
// right, so after 2*SIZE enabled samples the first bit sits at data[0].
module spm_prod_sipo
    import spm_drv_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              bit_in,
    output logic [2*SIZE-1:0] data,
    output logic              last,
    output logic              done
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(2*SIZE-1);

    logic [CW-1:0] cnt;

    assign last = en && (cnt == LAST_CNT);

    // Shift in one product bit per enabled cycle; done marks a full product.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            data <= {bit_in, data[2*SIZE-1:1]};
            cnt  <= cnt + CW'(1);
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spm_operand_driver.sv
// Host-side driver for the serial-parallel multiplier: holds x, streams y
// LSB first, and collects the serial product into a parallel result.
//
//   state | meaning
//   IDLE  | waiting for an operand pair; spm held in reset
//   CLR   | one cycle of spm reset so carries are flushed
//   SHIFT | streaming 2*SIZE bits of y (sign or zero extended)
//   DRAIN | y idle at 0, waiting for the last product bit to arrive
//   DONE  | product valid, waiting for the consumer
module spm_operand_driver
    import spm_drv_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int SPM_LAT = 1,
    parameter bit SIGNED  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_x,
    input  logic [SIZE-1:0]   in_y,
    output logic              spm_rst,
    output logic [SIZE-1:0]   spm_x,
    output logic              spm_y,
    input  logic              spm_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_p
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(2*SIZE-1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      shift_cnt;
    logic [SIZE-1:0]    ybuf;
    logic [SPM_LAT-1:0] act_dly;
    logic               accept;
    logic               cap_en;
    logic               cap_last;
    logic               cap_done;

    assign accept    = in_valid && in_ready;
    assign cap_en    = act_dly[SPM_LAT-1];
    assign spm_y     = (state == SHIFT) & ybuf[0];
    assign out_valid = (state == DONE) & cap_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == SHIFT_LAST) state_nxt = DRAIN;
            DRAIN:   if (cap_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and spm reset are registered from the upcoming state so they
    // read as their reset values while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            spm_rst  <= 1'b1;
        end else begin
            in_ready <= (state_nxt == IDLE);
            spm_rst  <= !((state_nxt == SHIFT) || (state_nxt == DRAIN));
        end
    end

    // Operand latch and y serialiser; an arithmetic shift keeps y's sign
    // bit feeding the upper half when signed.
    always_ff @(posedge clk) begin
        if (rst) begin
            spm_x     <= '0;
            ybuf      <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        spm_x <= in_x;
                        ybuf  <= in_y;
                    end
                end
                CLR: begin
                    shift_cnt <= '0;
                end
                SHIFT: begin
                    ybuf      <= {(SIGNED ? ybuf[SIZE-1] : 1'b0), ybuf[SIZE-1:1]};
                    shift_cnt <= shift_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Delay the shift window by the spm latency to form the capture window.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_dly <= '0;
        end else begin
            act_dly[0] <= (state == SHIFT);
            for (int i = 1; i < SPM_LAT; i++) begin
                act_dly[i] <= act_dly[i-1];
            end
        end
    end

    spm_prod_sipo #(
        .SIZE (SIZE)
    ) u_sipo (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == CLR),
        .en     (cap_en),
        .bit_in (spm_p),
        .data   (out_p),
        .last   (cap_last),
        .done   (cap_done)
    );

endmodule
